// File: rtl/calc_pkg.sv
// Shared types and helpers for the sequential calculator and its mul/div core.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Minimum of 1 so a counter of this width is always legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative datapath: one shift-add multiply or restoring-divide step per enabled cycle.
module seq_muldiv_core
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               step,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CW = clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH:0]     mul_sum, r_sh, diff;
  logic [2*WIDTH-1:0] step_val;

  // result is the post-step value so the owner can capture it on the last step edge.
  always_comb begin
    hi       = acc_q[2*WIDTH-1:WIDTH];
    lo       = acc_q[WIDTH-1:0];
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd_q} : '0);
    r_sh     = {hi, lo[WIDTH-1]};
    diff     = r_sh - {1'b0, opd_q};
    step_val = {mul_sum, lo[WIDTH-1:1]};
    if (div_q) begin
      if (!diff[WIDTH]) step_val = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      else              step_val = {r_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end
    result = step_val;
    done   = step && (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    acc_d = acc_q;
    opd_d = opd_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (start) begin
      acc_d = is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      opd_d = is_div ? b : a;
      div_d = is_div;
      cnt_d = '0;
    end else if (step) begin
      acc_d = step_val;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      opd_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      opd_q <= opd_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// Handshaked add/sub/mul/div calculator; mul and div iterate in seq_muldiv_core.
module seq_calculator
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero,
  output logic               borrow
);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dbz_q, dbz_d;
  logic               brw_q, brw_d;
  logic               core_start, core_step, core_done, core_is_div;
  logic [2*WIDTH-1:0] core_res;

  assign core_is_div = (op_t'(op) == OP_DIV);

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (core_start),
    .is_div (core_is_div),
    .a      (a),
    .b      (b),
    .step   (core_step),
    .done   (core_done),
    .result (core_res)
  );

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    dbz_d      = dbz_q;
    brw_d      = brw_q;
    core_start = 1'b0;
    core_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (op_t'(op))
            OP_ADD: begin
              res_d   = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
              dbz_d   = 1'b0;
              brw_d   = 1'b0;
              state_d = DONE;
            end
            OP_SUB: begin
              res_d   = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
              dbz_d   = 1'b0;
              brw_d   = (a < b);
              state_d = DONE;
            end
            OP_MUL: begin
              core_start = 1'b1;
              state_d    = CALC;
            end
            default: begin
              if (b == '0) begin
                res_d   = {a, {WIDTH{1'b1}}};
                dbz_d   = 1'b1;
                brw_d   = 1'b0;
                state_d = DONE;
              end else begin
                core_start = 1'b1;
                state_d    = CALC;
              end
            end
          endcase
        end
      end
      CALC: begin
        core_step = 1'b1;
        if (core_done) begin
          res_d   = core_res;
          dbz_d   = 1'b0;
          brw_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      brw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      brw_q   <= brw_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = res_q;
  assign div_by_zero = dbz_q;
  assign borrow      = brw_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Directed bench for seq_calculator at WIDTH=8: vector table plus backpressure/reset sequences.
module tb_seq_calculator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        div_by_zero;
  logic        borrow;

  int checks = 0;
  int errors = 0;

  seq_calculator #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .borrow      (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        dbz;
    logic        brw;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation, then wait (bounded) for out_valid; samples land #1 after posedge.
  task automatic run_op(input logic [1:0] o, input logic [7:0] ia, input logic [7:0] ib,
                        output int lat, output int low);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    op = o; a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h00; op = 2'b11;
    lat = 1;
    low = in_ready ? 0 : 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready) low++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, low, seen;

    vecs[0]  = '{2'b00, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1};
    vecs[1]  = '{2'b00, 8'd255, 8'd255, 16'h01FE, 1'b0, 1'b0, 1};
    vecs[2]  = '{2'b01, 8'd5,   8'd7,   16'hFFFE, 1'b0, 1'b1, 1};
    vecs[3]  = '{2'b01, 8'd7,   8'd5,   16'h0002, 1'b0, 1'b0, 1};
    vecs[4]  = '{2'b01, 8'd0,   8'd0,   16'h0000, 1'b0, 1'b0, 1};
    vecs[5]  = '{2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9};
    vecs[6]  = '{2'b10, 8'd0,   8'd13,  16'h0000, 1'b0, 1'b0, 9};
    vecs[7]  = '{2'b10, 8'd1,   8'd255, 16'h00FF, 1'b0, 1'b0, 9};
    vecs[8]  = '{2'b11, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 9};
    vecs[9]  = '{2'b11, 8'd9,   8'd0,   16'h09FF, 1'b1, 1'b0, 1};
    vecs[10] = '{2'b11, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0, 9};
    vecs[11] = '{2'b11, 8'd5,   8'd200, 16'h0500, 1'b0, 1'b0, 9};
    vecs[12] = '{2'b11, 8'd255, 8'd255, 16'h0001, 1'b0, 1'b0, 9};
    vecs[13] = '{2'b10, 8'd12,  8'd10,  16'h0078, 1'b0, 1'b0, 9};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},    32'd1);
    check("rst_out_valid", {31'd0, out_valid},   32'd0);
    check("rst_result",    {16'd0, result},      32'd0);
    check("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    check("rst_borrow",    {31'd0, borrow},      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, low);
      check($sformatf("v%0d_valid", i),  {31'd0, out_valid},   32'd1);
      check($sformatf("v%0d_result", i), {16'd0, result},      {16'd0, vecs[i].res});
      check($sformatf("v%0d_dbz", i),    {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      check($sformatf("v%0d_borrow", i), {31'd0, borrow},      {31'd0, vecs[i].brw});
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i),    low, vecs[i].lat);
      @(posedge clk); #1;
      check($sformatf("v%0d_idle_ready", i), {31'd0, in_ready},  32'd1);
      check($sformatf("v%0d_idle_valid", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: result held and new requests ignored while out_ready is low.
    out_ready = 1'b0;
    run_op(2'b10, 8'd12, 8'd10, lat, low);
    check("bp_latency", lat, 9);
    in_valid = 1'b1; op = 2'b00; a = 8'd1; b = 8'd2;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_%0d", k),  {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_ready_%0d", k),  {31'd0, in_ready},  32'd0);
      check($sformatf("bp_result_%0d", k), {16'd0, result},    32'h0078);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready},  32'd1);
    check("bp_release_result", {16'd0, result},   32'h0078);
    run_op(2'b01, 8'd5, 8'd7, lat, low);
    check("post_bp_latency", lat, 1);
    check("post_bp_result", {16'd0, result}, 32'hFFFE);
    check("post_bp_borrow", {31'd0, borrow}, 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset three cycles into a multiply.
    op = 2'b10; a = 8'd12; b = 8'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_calc_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("arst_in_ready",  {31'd0, in_ready},    32'd1);
    check("arst_out_valid", {31'd0, out_valid},   32'd0);
    check("arst_result",    {16'd0, result},      32'd0);
    check("arst_borrow",    {31'd0, borrow},      32'd0);
    check("arst_dbz",       {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("arst_no_valid", seen, 0);
    run_op(2'b00, 8'd1, 8'd1, lat, low);
    check("arst_add_latency", lat, 1);
    check("arst_add_result", {16'd0, result}, 32'h0002);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised, handshaked successor to the team's 4-bit combinational calculator.
- Operand width is generic; multiply and divide run as iterative multi-cycle operations, so the block closes timing at wide widths.
- Valid/ready on both input and output sides, plus status flags (divide-by-zero, borrow).
- Sits between an operand source (register file or test driver) and a result consumer on a single clock domain.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH bits; legal range 2..32.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept a new operation
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- op  in  2  00 add, 01 sub, 10 mul, 11 div
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  2*WIDTH  operation result
- div_by_zero  out  1  div with b==0 (valid with out_valid)
- borrow  out  1  sub with a<b (valid with out_valid)

Behaviour:
- Reset is asynchronous on rst high. FSM enters IDLE; in_ready=1, out_valid=0, result=0, div_by_zero=0, borrow=0; all internal counters and accumulators are cleared.
- FSM states and transitions:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready; a, b and op are registered at the accept edge.
  - From IDLE, add/sub go to DONE. Mul goes to CALC. Div goes to DONE if b==0, else to CALC.
  - CALC: in_ready=0. Exactly WIDTH iterations, one bit per cycle; counter runs 0..WIDTH-1; after the last iteration go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready go to IDLE.
- Latency from accept edge to out_valid high:
  - add/sub/div-by-zero: 1 cycle.
  - mul and nonzero div: WIDTH+1 cycles.
- No accept occurs in the cycle DONE is left; the next accept is possible on the following cycle (throughput is not pipelined).
- Arithmetic rules:
  - add: result = zero-extended a + b; carry appears in bit WIDTH.
  - sub: result = (zero-ext a - zero-ext b) mod 2^(2*WIDTH), i.e. two's-complement when negative; borrow = (a<b).
  - mul: unsigned shift-add. result = a*b, full 2*WIDTH bits, no overflow possible.
  - div: unsigned restoring division. result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder.
  - div with b==0: quotient all-ones, remainder = a, div_by_zero=1.
- Flags are 0 for every op they do not apply to.
- result and flags are held stable while out_valid=1 and out_ready=0 (backpressure). They change only on a new completion or on reset.
- in_valid, a, b and op are ignored in CALC and DONE; there is no abort.
- Reset asserted mid-CALC discards the operation immediately; no out_valid pulse follows.
- out_ready high while out_valid=0 has no effect.

Decomposition:
- Package calc_pkg holds:
  - op_t enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - state_t enum: IDLE, CALC, DONE.
  - Function clog2 for sizing the iteration counter.
- One sub-module is natural: seq_muldiv_core (WIDTH).
  - Contains the shared shift register/accumulator datapath performing one mul or div step per cycle.
  - Interface: start, is_div, a, b, step enable, done, 2*WIDTH result.
  - The top level owns the FSM, handshake, add/sub path and flags.

Test Plan:
- WIDTH=8, add a=200 b=100, out_ready=1 -> out_valid exactly 1 cycle after accept; result=0x012C; flags 0.
- sub a=5 b=7 -> result=0xFFFE, borrow=1, latency 1. Then sub a=7 b=5 -> result=0x0002, borrow=0.
- mul a=255 b=255 -> in_ready low 9 cycles; out_valid 9 cycles after accept; result=0xFE01. Also a=0 b=13 -> result=0.
- div a=200 b=7 -> result=0x041C (rem 4, quot 28) at 9 cycles. div a=9 b=0 -> result=0x09FF, div_by_zero=1, latency 1.
- Backpressure: mul 12*10 with out_ready=0 for 5 cycles after out_valid -> result=0x0078 held stable, in_ready=0. Raise out_ready -> IDLE next cycle, then a new add accepted.
- Reset mid-mul: assert rst 3 cycles into CALC -> all outputs return to reset values asynchronously; no out_valid afterwards. A new add 1+1 after release -> result=0x0002.
